// File: rtl/audio_play_sequencer_if.sv
// audio_play_sequencer_if: control, sample and status bundle between a player driver (master) and audio_play_sequencer (slave)
interface audio_play_sequencer_if #(parameter int DEPTH = 16);
  localparam int FW = $clog2(DEPTH) + 1;
  logic play_in;
  logic clr_in;
  logic wr_in;
  logic req_in;
  logic [23:0] wdata0_in;
  logic [23:0] wdata1_in;
  logic tick_out;
  logic [23:0] audio0_out;
  logic [23:0] audio1_out;
  logic [FW-1:0] fill_out;
  logic full_out;
  logic empty_out;
  logic irq_out;
  logic underrun_out;
  logic overflow_out;
  logic [1:0] state_out;
  modport master(
    output play_in, clr_in, wr_in, req_in, wdata0_in, wdata1_in,
    input tick_out, audio0_out, audio1_out, fill_out, full_out, empty_out,
    input irq_out, underrun_out, overflow_out, state_out
  );
  modport slave(
    input play_in, clr_in, wr_in, req_in, wdata0_in, wdata1_in,
    output tick_out, audio0_out, audio1_out, fill_out, full_out, empty_out,
    output irq_out, underrun_out, overflow_out, state_out
  );
endinterface

// File: rtl/audio_play_sequencer.sv
// audio_play_sequencer: stereo sample FIFO with IDLE/PRIME/RUN playback sequencing; define AUDIO_SEQ_UNDERRUN_REPEAT_EN to repeat the last frame on underrun instead of zeros
module audio_play_sequencer #(
  parameter int DEPTH = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int IRQ_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  audio_play_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
  state_t r_state;
  logic [23:0] r_mem0 [DEPTH];
  logic [23:0] r_mem1 [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [FW-1:0] r_fill;
  logic r_tick;
  logic r_irq;
  logic r_under;
  logic r_over;
  logic [23:0] r_a0;
  logic [23:0] r_a1;
  logic w_full;
  logic w_empty;
  logic w_req;
  logic w_pop;
  logic w_push;
  logic [FW-1:0] w_fill_nxt;
  assign w_full = r_fill == FW'(DEPTH);
  assign w_empty = r_fill == '0;
  assign w_req = r_state == RUN && bus.req_in && !bus.clr_in;
  assign w_pop = w_req && !w_empty;
  assign w_push = bus.wr_in && !bus.clr_in && (!w_full || w_pop);
  assign w_fill_nxt = r_fill + FW'(w_push) - FW'(w_pop);
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem0[r_wr] <= bus.wdata0_in;
      r_mem1[r_wr] <= bus.wdata1_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd <= '0;
      r_wr <= '0;
      r_fill <= '0;
      r_tick <= 1'b0;
      r_irq <= 1'b0;
      r_under <= 1'b0;
      r_over <= 1'b0;
      r_a0 <= '0;
      r_a1 <= '0;
    end else if (bus.clr_in) begin
      r_state <= bus.play_in ? PRIME : IDLE;
      r_rd <= '0;
      r_wr <= '0;
      r_fill <= '0;
      r_tick <= 1'b0;
      r_irq <= 1'b0;
      r_under <= 1'b0;
      r_over <= 1'b0;
    end else begin
      r_tick <= w_req;
      r_irq <= w_pop && !w_push && r_fill == FW'(IRQ_LEVEL);
      r_fill <= w_fill_nxt;
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
        r_a0 <= r_mem0[r_rd];
        r_a1 <= r_mem1[r_rd];
      end else if (w_req) begin
`ifdef AUDIO_SEQ_UNDERRUN_REPEAT_EN
        r_a0 <= r_a0;
        r_a1 <= r_a1;
`else
        r_a0 <= '0;
        r_a1 <= '0;
`endif
        r_under <= 1'b1;
      end
      if (bus.wr_in && w_full && !w_pop)
        r_over <= 1'b1;
      r_state <= r_state == IDLE ? (bus.play_in ? PRIME : IDLE) :
                 r_state == PRIME ? (!bus.play_in ? IDLE : w_fill_nxt >= FW'(PRIME_LEVEL) ? RUN : PRIME) :
                 (bus.play_in ? RUN : IDLE);
    end
  end
  assign bus.tick_out = r_tick;
  assign bus.audio0_out = r_a0;
  assign bus.audio1_out = r_a1;
  assign bus.fill_out = r_fill;
  assign bus.full_out = w_full;
  assign bus.empty_out = w_empty;
  assign bus.irq_out = r_irq;
  assign bus.underrun_out = r_under;
  assign bus.overflow_out = r_over;
  assign bus.state_out = r_state;
endmodule
